cobs_axis_decoder: RTL and testbench
====================================

// Module: cobs_axis_decoder
// PURPOSE
//   Inverse of the COBS encode path: consumes a 0x00-delimited COBS byte stream
//   (host -> FPGA over USB) and emits the decoded payload bytes as AXI-Stream.
//   tlast marks the final byte of each frame. Sits directly downstream of the
//   byte-wide encoded stream, so loopback of encoder output must reproduce the
//   original bytes. Feeds command parsing / width up-conversion stages.
// PARAMETERS
//   DATA_WIDTH  8  byte width of both streams; elaboration error if not 8
//   FLAG_ERRORS 1  1: truncated frames end with tuser=1; 0: tuser tied 0
// PORTS
//   clk           input   1   system clock; both interfaces use it
//   rst           input   1   synchronous, active-high reset
//   encoded_data  axis_interface.Sink    8  COBS bytes in (tdata/tvalid/tready; tlast ignored)
//   decoded_data  axis_interface.Source  8  decoded bytes out; tlast = frame end, tuser = error
//   frame_error   output  1   one-cycle pulse when a malformed/truncated frame is detected
// BEHAVIOUR
//   Reset: decoded tvalid=0, tlast=0, tuser=0, tdata=0; frame_error=0;
//     encoded tready=0 in the reset cycle; state=CODE; pending/zero_owed cleared.
//     Reset mid-frame discards all partial state; next byte is treated as a code byte.
//   Constant outputs: decoded tkeep='1, tid='0, tdest='0.
//   Datapath: one-byte pending register + output register. Each accepted input byte
//     produces at most one output byte, so encoded tready = !out_valid || decoded.tready.
//   State CODE (expect code byte c):
//     c==0x00 -> stray delimiter: ignore, no output, stay CODE.
//     c!=0x00 -> if zero_owed: release pending to out, pending=0x00.
//                remaining=c-1; code_ff=(c==0xFF); go DATA if remaining>0,
//                else stay CODE with zero_owed=!code_ff.
//   State DATA (remaining>0), byte b:
//     b!=0x00 -> release pending (if valid) to out; pending=b; remaining--;
//                on remaining reaching 0: zero_owed=!code_ff, go CODE.
//     b==0x00 -> truncated frame: release pending with tlast=1, tuser=FLAG_ERRORS;
//                frame_error=1; go CODE; clear zero_owed/pending.
//   Delimiter 0x00 in CODE after a frame has started: release pending with tlast=1,
//     tuser=0; zero_owed is discarded (no trailing zero); clear pending; frame ends.
//   Empty frame (01 00) or frame with no pending byte at delimiter: nothing emitted
//     (AXIS cannot carry zero-length packets); no error.
//   Latency: a decoded byte leaves 1 cycle after the *next* encoded byte is accepted
//     (needs one-byte lookahead to place tlast / drop the final phantom zero).
//   Backpressure: out register holds tdata/tlast/tuser stable while tvalid && !tready;
//     input stalls; no byte is dropped or duplicated. Accept+drain in the same cycle
//     is allowed (full throughput, 1 byte/cycle).
//   0xFF code: block of 254 data bytes with no implied zero; remaining is 8-bit, 0xFF-1=254
//     never wraps.
// TESTING
//   1 Send 03 71 69 00 -> out 71(tlast0), 69(tlast1, tuser0); no frame_error.
//   2 Send 01 01 00 -> single byte 00 with tlast1 (decoded payload {00}).
//   3 Send 02 11 01 01 00 -> 11, 00, 00(tlast1); checks owed-zero insertion ordering.
//   4 Send FF + 254 bytes 01..FE + 02 AA 00 -> 01..FE then AA(tlast1), no zero between FE and AA.
//   5 Send 04 11 22 00 (truncated) -> 11, 22(tlast1,tuser1); frame_error pulses once;
//     then 02 33 00 -> 33(tlast1,tuser0).
//   6 Random tready (50%) during test 4 plus rst asserted mid-frame, then test 1 ->
//     no drop/dup before reset; post-reset output exactly 71, 69(tlast1); leading 00 00 ignored.

Source files
------------

// File: rtl/cobs_axis_decoder.sv
// COBS stream decoder: 0x00-delimited COBS bytes in, decoded AXI-Stream bytes out with tlast on each frame end.
// Latency: a decoded byte appears 1 cycle after the following encoded byte is accepted (one-byte lookahead).
// Backpressure: input tready = !out_valid || out_tready; the output register holds stable while stalled.
module cobs_axis_decoder #(
  parameter int DATA_WIDTH  = 8,
  parameter int FLAG_ERRORS = 1,
  parameter int ID_WIDTH    = 8,
  parameter int DEST_WIDTH  = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  // encoded COBS byte stream (sink)
  input  logic [DATA_WIDTH-1:0]   i_enc_tdata,
  input  logic                    i_enc_tvalid,
  output logic                    o_enc_tready,
  // decoded payload stream (source)
  output logic [DATA_WIDTH-1:0]   o_dec_tdata,
  output logic                    o_dec_tvalid,
  input  logic                    i_dec_tready,
  output logic                    o_dec_tlast,
  output logic                    o_dec_tuser,
  output logic [DATA_WIDTH/8-1:0] o_dec_tkeep,
  output logic [ID_WIDTH-1:0]     o_dec_tid,
  output logic [DEST_WIDTH-1:0]   o_dec_tdest,
  output logic                    o_frame_error
);

  if (DATA_WIDTH != 8) begin : g_bad_width
    $error("cobs_axis_decoder: DATA_WIDTH must be 8");
  end

  typedef enum logic {ST_CODE = 1'b0, ST_DATA = 1'b1} state_t;

  state_t                r_state, w_state_nxt;
  logic [7:0]            r_remaining, w_rem_nxt;
  logic                  r_code_ff, w_code_ff_nxt;
  logic                  r_zero_owed, w_zero_owed_nxt;
  logic                  r_pend_vld, w_pend_vld_nxt;
  logic [DATA_WIDTH-1:0] r_pend_dat, w_pend_dat_nxt;
  logic                  r_out_vld, r_out_last, r_out_user;
  logic [DATA_WIDTH-1:0] r_out_dat;
  logic                  r_frame_error;

  logic                  w_in_fire, w_in_zero;
  logic [7:0]            w_code;
  logic                  w_emit, w_emit_last, w_emit_user, w_err;

  // Each accepted byte releases at most one byte, so a free or draining output slot is enough.
  assign o_enc_tready = !i_rst && (!r_out_vld || i_dec_tready);
  assign w_in_fire    = i_enc_tvalid && o_enc_tready;
  assign w_in_zero    = (i_enc_tdata == '0);
  assign w_code       = i_enc_tdata[7:0];

  assign o_dec_tdata   = r_out_dat;
  assign o_dec_tvalid  = r_out_vld;
  assign o_dec_tlast   = r_out_last;
  assign o_dec_tuser   = r_out_user;
  assign o_dec_tkeep   = '1;
  assign o_dec_tid     = '0;
  assign o_dec_tdest   = '0;
  assign o_frame_error = r_frame_error;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_CODE;
    else       r_state <= w_state_nxt;
  end

  // Next state: a code byte > 1 opens a data run; the run ends on its last byte or on a stray zero
  always_comb begin
    w_state_nxt = r_state;
    if (w_in_fire) begin
      if (r_state == ST_CODE) begin
        if (!w_in_zero && w_code != 8'd1) w_state_nxt = ST_DATA;
      end else begin
        if (w_in_zero || r_remaining == 8'd1) w_state_nxt = ST_CODE;
      end
    end
  end

  // Output/datapath decisions: what gets released from pending and how pending/run state update
  always_comb begin
    w_emit          = 1'b0;
    w_emit_last     = 1'b0;
    w_emit_user     = 1'b0;
    w_err           = 1'b0;
    w_pend_vld_nxt  = r_pend_vld;
    w_pend_dat_nxt  = r_pend_dat;
    w_rem_nxt       = r_remaining;
    w_code_ff_nxt   = r_code_ff;
    w_zero_owed_nxt = r_zero_owed;
    if (w_in_fire) begin
      if (r_state == ST_CODE) begin
        if (w_in_zero) begin
          // frame delimiter: the held byte is the last one, any owed zero is the phantom terminator
          w_emit          = r_pend_vld;
          w_emit_last     = 1'b1;
          w_pend_vld_nxt  = 1'b0;
          w_pend_dat_nxt  = '0;
          w_zero_owed_nxt = 1'b0;
        end else begin
          // a further code byte proves the owed zero is real payload
          if (r_zero_owed) begin
            w_emit         = r_pend_vld;
            w_pend_vld_nxt = 1'b1;
            w_pend_dat_nxt = '0;
          end
          w_rem_nxt       = w_code - 8'd1;
          w_code_ff_nxt   = (w_code == 8'hFF);
          // only code 0x01 has an empty run; it always owes a zero
          w_zero_owed_nxt = (w_code == 8'd1);
        end
      end else begin
        if (w_in_zero) begin
          // delimiter inside a data run: frame was cut short
          w_emit          = r_pend_vld;
          w_emit_last     = 1'b1;
          w_emit_user     = (FLAG_ERRORS != 0);
          w_err           = 1'b1;
          w_pend_vld_nxt  = 1'b0;
          w_pend_dat_nxt  = '0;
          w_zero_owed_nxt = 1'b0;
        end else begin
          w_emit         = r_pend_vld;
          w_pend_vld_nxt = 1'b1;
          w_pend_dat_nxt = i_enc_tdata;
          w_rem_nxt      = r_remaining - 8'd1;
          if (r_remaining == 8'd1) w_zero_owed_nxt = !r_code_ff;
        end
      end
    end
  end

  // Pending byte, run bookkeeping, output register and error pulse
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_remaining   <= '0;
      r_code_ff     <= 1'b0;
      r_zero_owed   <= 1'b0;
      r_pend_vld    <= 1'b0;
      r_pend_dat    <= '0;
      r_out_vld     <= 1'b0;
      r_out_dat     <= '0;
      r_out_last    <= 1'b0;
      r_out_user    <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_remaining   <= w_rem_nxt;
      r_code_ff     <= w_code_ff_nxt;
      r_zero_owed   <= w_zero_owed_nxt;
      r_pend_vld    <= w_pend_vld_nxt;
      r_pend_dat    <= w_pend_dat_nxt;
      r_frame_error <= w_err;
      if (w_emit) begin
        r_out_vld  <= 1'b1;
        r_out_dat  <= r_pend_dat;
        r_out_last <= w_emit_last;
        r_out_user <= w_emit_user;
      end else if (i_dec_tready) begin
        r_out_vld  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cobs_axis_decoder.sv
// Scoreboard bench for cobs_axis_decoder: directed COBS frames in, expected decoded beats queued.
// A negedge monitor pops and compares every handshaked output beat and counts frame_error pulses.
// Output ready is either held high or randomised per cycle.
module tb_cobs_axis_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] enc_tdata = 8'h00;
  logic       enc_tvalid = 1'b0;
  logic       enc_tready;
  logic [7:0] dec_tdata;
  logic       dec_tvalid;
  logic       dec_tready = 1'b1;
  logic       dec_tlast, dec_tuser;
  logic [0:0] dec_tkeep;
  logic [7:0] dec_tid, dec_tdest;
  logic       frame_error;

  always #5 clk = ~clk;

  cobs_axis_decoder #(.DATA_WIDTH(8), .FLAG_ERRORS(1), .ID_WIDTH(8), .DEST_WIDTH(8)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_enc_tdata(enc_tdata), .i_enc_tvalid(enc_tvalid), .o_enc_tready(enc_tready),
    .o_dec_tdata(dec_tdata), .o_dec_tvalid(dec_tvalid), .i_dec_tready(dec_tready),
    .o_dec_tlast(dec_tlast), .o_dec_tuser(dec_tuser), .o_dec_tkeep(dec_tkeep),
    .o_dec_tid(dec_tid), .o_dec_tdest(dec_tdest), .o_frame_error(frame_error)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       u;
  } beat_t;

  beat_t      exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         err_cnt = 0;
  bit         rand_ready = 1'b0;

  // output ready: held high or 50% random, changed just after each rising edge
  always @(posedge clk) begin
    #1;
    if (rand_ready) dec_tready = ($urandom_range(0, 1) == 1);
    else            dec_tready = 1'b1;
  end

  // monitor: compare every output handshake against the scoreboard
  always @(negedge clk) begin
    beat_t got, e;
    if (!rst) begin
      if (frame_error) err_cnt++;
      if (dec_tvalid && dec_tready) begin
        got = '{d: dec_tdata, l: dec_tlast, u: dec_tuser};
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL out_extra: got data=%02h last=%0d user=%0d, required no beat", got.d, got.l, got.u);
        end else begin
          e = exp_q.pop_front();
          if (got != e) begin
            n_bad++;
            $display("FAIL out_beat: got data=%02h last=%0d user=%0d, required data=%02h last=%0d user=%0d",
                     got.d, got.l, got.u, e.d, e.l, e.u);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic expect_beat(input logic [7:0] d, input logic l, input logic u);
    exp_q.push_back('{d: d, l: l, u: u});
  endtask

  // called just after a rising edge; returns just after the edge that accepted the byte
  task automatic send_byte(input logic [7:0] b);
    int  t;
    bit  acc;
    t = 0;
    acc = 1'b0;
    enc_tdata  = b;
    enc_tvalid = 1'b1;
    while (!acc && t < 1000) begin
      @(negedge clk);
      acc = enc_tready;
      @(posedge clk);
      #1;
      t++;
    end
    enc_tvalid = 1'b0;
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: byte %02h not accepted in 1000 cycles", b);
    end
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(posedge clk);
      #1;
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic send_ff_block();
    send_byte(8'hFF);
    for (int i = 1; i <= 254; i++) begin
      send_byte(i[7:0]);
      expect_beat(i[7:0], 1'b0, 1'b0);
    end
    send_byte(8'h02);
    send_byte(8'hAA);
    send_byte(8'h00);
    expect_beat(8'hAA, 1'b1, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    check({tag, "_tvalid"}, dec_tvalid, 0);
    check({tag, "_tready"}, enc_tready, 0);
    check({tag, "_tdata"}, dec_tdata, 0);
    check({tag, "_tlast_tuser"}, {dec_tlast, dec_tuser}, 0);
    check({tag, "_frame_error"}, frame_error, 0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    check_reset_outputs("reset");
    check("const_tkeep_tid_tdest", {dec_tkeep, dec_tid, dec_tdest}, 32'h1_00_00);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: basic two-byte frame
    expect_beat(8'h71, 1'b0, 1'b0);
    expect_beat(8'h69, 1'b1, 1'b0);
    send_byte(8'h03); send_byte(8'h71); send_byte(8'h69); send_byte(8'h00);
    wait_drain("t1");
    check("t1_frame_error_cnt", err_cnt, 0);

    // 2: payload consisting of a single zero
    expect_beat(8'h00, 1'b1, 1'b0);
    send_byte(8'h01); send_byte(8'h01); send_byte(8'h00);
    wait_drain("t2");

    // 3: owed zeros inserted between runs, trailing phantom dropped
    expect_beat(8'h11, 1'b0, 1'b0);
    expect_beat(8'h00, 1'b0, 1'b0);
    expect_beat(8'h00, 1'b1, 1'b0);
    send_byte(8'h02); send_byte(8'h11); send_byte(8'h01); send_byte(8'h01); send_byte(8'h00);
    wait_drain("t3");

    // 4: 0xFF block carries no implied zero
    send_ff_block();
    wait_drain("t4");

    // 5: truncated frame flagged, then a clean frame
    expect_beat(8'h11, 1'b0, 1'b0);
    expect_beat(8'h22, 1'b1, 1'b1);
    send_byte(8'h04); send_byte(8'h11); send_byte(8'h22); send_byte(8'h00);
    wait_drain("t5a");
    check("t5_frame_error_cnt", err_cnt, 1);
    expect_beat(8'h33, 1'b1, 1'b0);
    send_byte(8'h02); send_byte(8'h33); send_byte(8'h00);
    wait_drain("t5b");
    check("t5b_frame_error_cnt", err_cnt, 1);

    // 6: random backpressure over the long block, then reset mid-frame
    rand_ready = 1'b1;
    send_ff_block();
    wait_drain("t6_rand");
    rand_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_beat(8'h11, 1'b0, 1'b0);
    send_byte(8'h05); send_byte(8'h11); send_byte(8'h22);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("midreset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    expect_beat(8'h71, 1'b0, 1'b0);
    expect_beat(8'h69, 1'b1, 1'b0);
    send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h03); send_byte(8'h71); send_byte(8'h69); send_byte(8'h00);
    wait_drain("t6_post_reset");
    check("final_frame_error_cnt", err_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
